// File: rtl/snn_tdm_scheduler.sv
// rtl/snn_tdm_scheduler.sv - time-multiplexed quadratic integrate-and-fire neuron sweep scheduler
// One update datapath serves all neurons; spikes are queued for a downstream router.
module snn_tdm_scheduler #(
  parameter int N_NEURONS  = 4,
  parameter int ID_W       = 2,
  parameter int THRESH     = 50,
  parameter int V_RESET    = -20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic [8*N_NEURONS-1:0] i_syn,
  output logic                   busy,
  output logic                   sweep_done,
  output logic                   spike_valid,
  output logic [ID_W-1:0]        spike_id,
  input  logic                   spike_ready,
  input  logic [ID_W-1:0]        v_rd_addr,
  output logic [7:0]             v_rd_data,
  output logic                   spike_ovf,
  output logic                   tick_miss
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   idx;
  logic signed [7:0] v_q, i_q;
  logic [7:0]        mem [N_NEURONS];

  logic [ID_W-1:0]   fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;

  logic                last_idx;
  logic                spike_hit;
  logic signed [11:0]  v_ext, i_ext, v_sh, sum;
  logic [7:0]          v_new;
  logic                pop, do_push;

  assign last_idx = (idx == ID_W'(N_NEURONS - 1));

  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    sweep_done = (state == DONE);
    case (state)
      IDLE:    if (tick) state_nxt = LOAD;
      LOAD:    state_nxt = WRITE;
      WRITE:   state_nxt = last_idx ? DONE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // 12-bit signed arithmetic cannot overflow: |sum| stays below 400.
  always_comb begin
    v_ext     = 12'(v_q);
    i_ext     = 12'(i_q);
    v_sh      = v_ext >>> 3;
    sum       = v_ext + (i_ext >>> 2) + v_sh * v_sh;
    spike_hit = (state == WRITE) && (int'(v_q) >= THRESH);
    if (sum > 12'sd127)
      v_new = 8'd127;
    else if (sum < -12'sd128)
      v_new = 8'h80;
    else
      v_new = sum[7:0];
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      v_q       <= '0;
      i_q       <= '0;
      tick_miss <= 1'b0;
      for (int k = 0; k < N_NEURONS; k++) mem[k] <= '0;
    end else begin
      state <= state_nxt;
      if (tick && state != IDLE) tick_miss <= 1'b1;
      case (state)
        IDLE: if (tick) idx <= '0;
        LOAD: begin
          v_q <= mem[idx];
          i_q <= i_syn[int'(idx)*8 +: 8];
        end
        WRITE: begin
          mem[idx] <= spike_hit ? 8'(V_RESET) : v_new;
          if (!last_idx) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop     = spike_valid && spike_ready;
  assign do_push = spike_hit && ((count < (PTR_W+1)'(FIFO_DEPTH)) || pop);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      spike_ovf <= 1'b0;
      for (int k = 0; k < FIFO_DEPTH; k++) fifo[k] <= '0;
    end else begin
      if (spike_hit && !do_push) spike_ovf <= 1'b1;
      if (do_push) begin
        fifo[wr_ptr] <= idx;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign spike_valid = (count != '0);
  assign spike_id    = fifo[rd_ptr];
  assign v_rd_data   = mem[v_rd_addr];

endmodule

// File: tb/tb_snn_tdm_scheduler.sv
// tb/tb_snn_tdm_scheduler.sv - scoreboard bench for snn_tdm_scheduler
// Reference neuron model uses floor division and integer clamping; spikes/done pulses checked by a monitor.
module tb_snn_tdm_scheduler;
  localparam int N     = 4;
  localparam int ID_W  = 2;
  localparam int DEPTH = 4;

  logic             clk = 0;
  logic             rst_n;
  logic             tick;
  logic [8*N-1:0]   i_syn;
  logic             busy, sweep_done, spike_valid, spike_ready;
  logic [ID_W-1:0]  spike_id, v_rd_addr;
  logic [7:0]       v_rd_data;
  logic             spike_ovf, tick_miss;

  snn_tdm_scheduler #(.N_NEURONS(N), .ID_W(ID_W), .THRESH(50), .V_RESET(-20), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .i_syn(i_syn), .busy(busy), .sweep_done(sweep_done),
    .spike_valid(spike_valid), .spike_id(spike_id), .spike_ready(spike_ready),
    .v_rd_addr(v_rd_addr), .v_rd_data(v_rd_data), .spike_ovf(spike_ovf), .tick_miss(tick_miss)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int model_v [N];
  int lat_i [N];
  int exp_spk [$];
  int done_q [$];
  bit model_ovf = 0, model_miss = 0;
  bit bp = 0, rnd_ready = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int fdiv(input int a, input int b);
    return (a >= 0) ? a / b : -((-a + b - 1) / b);
  endfunction

  function automatic int step(input int v, input int i);
    int s;
    if (v >= 50) return -20;
    s = v + fdiv(i, 4) + fdiv(v, 8) * fdiv(v, 8);
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  function automatic logic [8*N-1:0] rand_vec();
    logic [8*N-1:0] r;
    for (int k = 0; k < N; k++) r[8*k +: 8] = 8'($urandom);
    return r;
  endfunction

  // Monitor: every handshake and every sweep_done pulse must match an expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (spike_valid && spike_ready) begin
        if (exp_spk.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL spike_unexpected: got id %0d expected none", spike_id);
        end else check("spike_id", int'(spike_id), exp_spk.pop_front());
      end
      if (sweep_done) begin
        if (done_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL done_unexpected: got pulse at cycle %0d expected none", cyc);
        end else check("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  initial begin
    spike_ready = 0;
    forever begin
      @(posedge clk); #1;
      spike_ready = bp ? 1'b0 : (rnd_ready ? ($urandom_range(3) != 0) : 1'b1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Neuron k is loaded during cycle 1+2k after the tick cycle and written during 2+2k.
  task automatic do_sweep(input bit rand_i, input logic [8*N-1:0] fixed_i, input int miss_at);
    logic [8*N-1:0] cur;
    int k;
    @(posedge clk); #1;
    cur = rand_i ? rand_vec() : fixed_i;
    i_syn = cur;
    tick = 1;
    done_q.push_back(cyc + 2*N + 1);
    for (int c = 1; c <= 2*N + 1; c++) begin
      @(posedge clk); #1;
      tick = (c == miss_at);
      if (c == miss_at) model_miss = 1;
      if (rand_i) begin cur = rand_vec(); i_syn = cur; end
      if (c % 2 == 1 && c < 2*N) begin
        k = (c - 1) / 2;
        lat_i[k] = int'($signed(cur[8*k +: 8]));
      end else if (c % 2 == 0) begin
        k = c / 2 - 1;
        v_rd_addr = ID_W'(k);
        #1 check("rd_prewrite", int'($signed(v_rd_data)), model_v[k]);
        if (model_v[k] >= 50) begin
          if (exp_spk.size() < DEPTH) exp_spk.push_back(k);
          else model_ovf = 1;
        end
        model_v[k] = step(model_v[k], lat_i[k]);
      end
    end
    @(posedge clk); #1;
    tick = 0;
  endtask

  task automatic post_check();
    for (int k = 0; k < N; k++) begin
      v_rd_addr = ID_W'(k);
      #1 check($sformatf("mem%0d", k), int'($signed(v_rd_data)), model_v[k]);
    end
    check("tick_miss", int'(tick_miss), int'(model_miss));
    check("spike_ovf", int'(spike_ovf), int'(model_ovf));
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_spk.size() != 0 || spike_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_in_time", int'(t < 300), 1);
  endtask

  int dir_v0 [6] = '{10, 21, 35, 61, -20, -1};

  initial begin
    rst_n = 1; tick = 0; i_syn = '0; v_rd_addr = '0;
    for (int k = 0; k < N; k++) model_v[k] = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(sweep_done), 0);
    check("rst_valid", int'(spike_valid), 0);
    check("rst_id", int'(spike_id), 0);
    post_check();
    @(posedge clk); #1;
    rst_n = 0;

    for (int s = 0; s < 6; s++) begin
      do_sweep(0, {24'd0, 8'd40}, -1);
      drain();
      v_rd_addr = '0;
      #1 check($sformatf("dir_v0_%0d", s), int'($signed(v_rd_data)), dir_v0[s]);
      post_check();
    end

    do_sweep(0, {24'd0, 8'd40}, 3);
    drain();
    post_check();

    rnd_ready = 1;
    for (int s = 0; s < 20; s++) begin
      do_sweep(1, '0, -1);
      drain();
      post_check();
    end
    rnd_ready = 0;

    bp = 1;
    repeat (2) @(posedge clk);
    for (int s = 0; s < 8; s++) do_sweep(0, {N{8'd127}}, -1);
    #1;
    check("bp_valid", int'(spike_valid), 1);
    post_check();
    bp = 0;
    drain();
    check("valid_after_drain", int'(spike_valid), 0);

    bp = 1;
    @(posedge clk); #1;
    tick = 1;
    @(posedge clk); #1;
    tick = 0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(sweep_done), 0);
    check("abort_valid", int'(spike_valid), 0);
    for (int k = 0; k < N; k++) model_v[k] = 0;
    exp_spk.delete();
    model_ovf = 0; model_miss = 0;
    post_check();
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    bp = 0;

    rnd_ready = 1;
    for (int s = 0; s < 4; s++) begin
      do_sweep(1, '0, -1);
      drain();
      post_check();
    end
    repeat (4) @(posedge clk);
    check("done_q_empty", done_q.size(), 0);
    check("spk_q_empty", exp_spk.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/snn_tdm_scheduler.md
Name: snn_tdm_scheduler

Overview:
Time-multiplexes one quadratic integrate-and-fire update datapath across N_NEURONS virtual neurons. Each neuron's 8-bit signed membrane potential is held in an internal register file. On each external tick, the block sweeps all neurons in index order. Spikes are queued in a small FIFO and drained by the downstream router over a valid/ready handshake.

Parameters:
N_NEURONS, 4, number of virtual neurons (2..16)
ID_W, 2, width of neuron index, equal to clog2(N_NEURONS)
THRESH, 50, signed spike threshold
V_RESET, -20, signed post-spike membrane value
FIFO_DEPTH, 4, spike FIFO entries (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high (rst_n=1 resets)
tick  in  1  single-cycle request to start one update sweep
i_syn  in  8*N_NEURONS  packed signed synaptic currents; neuron k occupies bits [8k+7:8k]
busy  out  1  sweep in progress
sweep_done  out  1  one-cycle pulse after the last neuron is written
spike_valid  out  1  FIFO non-empty
spike_id  out  ID_W  neuron index at FIFO head
spike_ready  in  1  consumer accepts the head entry when spike_valid && spike_ready
v_rd_addr  in  ID_W  debug read index
v_rd_data  out  8  combinational read of the membrane register at v_rd_addr
spike_ovf  out  1  sticky: a spike was dropped because the FIFO was full
tick_miss  out  1  sticky: a tick arrived while busy

Behaviour:
- Reset (async, rst_n=1):
  - All membrane registers = 0; state = IDLE; FIFO empty.
  - busy, sweep_done, spike_valid, spike_ovf, tick_miss = 0; spike_id = 0.
- Sticky flags clear only on reset.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - tick=1 -> LOAD with idx=0; busy=1 from the next cycle.
- LOAD:
  - Register V=mem[idx] and I=i_syn slice idx.
  - i_syn is sampled here only; changes at other times do not affect neuron idx.
  - Next state is WRITE.
- WRITE: compute and store the result.
  - If V >= THRESH (signed): mem[idx] <= V_RESET, and push idx into the spike FIFO.
  - Else: mem[idx] <= sat8(V + (I>>>2) + (V>>>3)*(V>>>3)).
    - Shifts are arithmetic (floor).
    - Sum is computed at 12-bit signed width.
    - sat8 clamps the result to [-128, 127].
  - If idx == N_NEURONS-1 -> DONE; else idx++ and return to LOAD.
- DONE:
  - sweep_done=1 for this one cycle; busy=0 from the next cycle.
  - Next state is IDLE.
- Sweep latency: tick at cycle 0 -> sweep_done asserted at cycle 2*N_NEURONS+1.
  - busy is high for 2*N_NEURONS+1 cycles.
- tick while busy or in DONE: ignored; tick_miss <= 1. The sweep is not restarted.
- Spike FIFO:
  - Push from WRITE; pop when spike_valid && spike_ready.
  - Push and pop in the same cycle on a full FIFO: both succeed, no overflow.
  - Push when full with no pop: entry dropped, spike_ovf <= 1. The membrane is still reset to V_RESET.
  - Pop when empty: no effect.
  - spike_id/spike_valid are registered FIFO-head outputs. Order is first-in, first-out.
- A spike emitted in sweep s is visible on spike_valid no earlier than the cycle after its WRITE.
- The debug read has no side effects and may read a neuron being updated. It returns the pre-write value until the WRITE clock edge.
- Reset mid-sweep aborts immediately. All state returns to reset values, and no partial sweep_done is produced.

Test Plan:
- Reset, then 4 ticks with i_syn[0]=40 and spike_ready=1 -> mem[0] = 10, 21, 35, 61. No spike yet; sweep_done follows each tick 9 cycles later with N=4.
- 5th tick -> neuron 0 reaches 61 >= 50 -> mem[0]=-20; spike_id=0 is delivered. 6th tick -> mem[0] = -20 + 10 + (-3)*(-3) = -1.
- Saturation: one sweep with mem[2] at -128 and i_syn[2]=127 -> -128+31+256=159 -> mem[2]=127. Next sweep -> spike for id 2 and mem[2]=-20.
- Back-pressure: spike_ready=0, all neurons above threshold over 2 sweeps -> FIFO holds ids 0,1,2,3 in order; later spikes are dropped; spike_ovf=1. Raise spike_ready -> ids drain 0,1,2,3, then spike_valid=0.
- Tick at cycle 3 of a sweep -> ignored: tick_miss=1 and sweep_done pulses exactly once. Assert rst_n mid-sweep -> busy=0 and all mem=0 immediately; no sweep_done.
